// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point widths, limits and state encoding for the neuron layer stages.
// Q2.12 activations, Q4.8 weights, Q3.8 pre-activations.
package nn_fixed_pkg;

    localparam int ACT_W  = 32'sd14;
    localparam int WGT_W  = 32'sd12;
    localparam int X_W    = 32'sd12;
    localparam int PROD_W = ACT_W + WGT_W;

    // Symmetric range keeps |x| representable in the sigmoid stage.
    localparam int X_MAX  = 32'sd2047;
    localparam int X_MIN  = -32'sd2047;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        OUT   = 2'd2
    } mac_state_t;

    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 32'sd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_preact_mac_if.sv
// Streamed activation/weight input and pre-activation result handshake for the MAC stage.
// slave is the MAC's view, master the upstream/downstream environment's view.
interface neuron_preact_mac_if;
    import nn_fixed_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic signed [ACT_W-1:0]  s_act;
    logic signed [WGT_W-1:0]  s_wgt;
    logic                     s_last;
    logic signed [X_W-1:0]    bias;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [X_W-1:0]    m_x;
    logic                     m_sat;
    logic                     m_short;

    modport slave (
        input  s_valid, s_act, s_wgt, s_last, bias, m_ready,
        output s_ready, m_valid, m_x, m_sat, m_short
    );

    modport master (
        output s_valid, s_act, s_wgt, s_last, bias, m_ready,
        input  s_ready, m_valid, m_x, m_sat, m_short
    );

endinterface

// File: rtl/preact_sat.sv
// Arithmetic right shift (floor) of a wide accumulator followed by a clamp to
// the symmetric Q3.8 range; sat_o flags when the clamp was applied.
module preact_sat
    import nn_fixed_pkg::*;
#(
    parameter int IN_W  = 31,
    parameter int SHIFT = 12
) (
    input  logic signed [IN_W-1:0] acc_i,
    output logic signed [X_W-1:0]  x_o,
    output logic                   sat_o
);

    localparam logic signed [IN_W-1:0] HI_LIM = IN_W'(X_MAX);
    localparam logic signed [IN_W-1:0] LO_LIM = IN_W'(X_MIN);

    logic signed [IN_W-1:0] shifted_s;

    assign shifted_s = acc_i >>> SHIFT;

    // Clamp the scaled value into [X_MIN, X_MAX].
    always_comb begin
        x_o   = shifted_s[X_W-1:0];
        sat_o = 1'b0;
        if (shifted_s > HI_LIM) begin
            x_o   = X_W'(X_MAX);
            sat_o = 1'b1;
        end else if (shifted_s < LO_LIM) begin
            x_o   = X_W'(X_MIN);
            sat_o = 1'b1;
        end else begin
            x_o   = shifted_s[X_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/neuron_preact_mac.sv
// Sequential MAC computing one neuron's pre-activation bias + sum(act*wgt) over a
// streamed vector, then scaling and saturating it to Q3.8 for the sigmoid stage.
module neuron_preact_mac
    import nn_fixed_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int SHIFT = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuron_preact_mac_if.slave    bus
);

    localparam int ACC_W = 27 + clog2(N_IN);
    localparam int CNT_W = (clog2(N_IN) > 0) ? clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    mac_state_t                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      pend_q, pend_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [X_W-1:0]     bias_q, bias_d;
    logic                      short_q, short_d;
    logic signed [X_W-1:0]     m_x_q, m_x_d;
    logic                      m_sat_q, m_sat_d;
    logic                      m_short_q, m_short_d;

    logic                      beat_s;
    logic                      end_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic signed [ACC_W-1:0]   bias_ext_s;
    logic signed [ACC_W-1:0]   acc_final_s;
    logic signed [X_W-1:0]     sat_x_s;
    logic                      sat_flag_s;

    assign beat_s      = bus.s_valid && (state_q == ACC);
    assign end_s       = beat_s && (bus.s_last || (cnt_q == CNT_LAST));
    // Only a pending product contributes; bubbles leave the accumulator unchanged.
    assign prod_ext_s  = pend_q ? ACC_W'(prod_q) : {ACC_W{1'b0}};
    assign bias_ext_s  = ACC_W'(bias_q) <<< SHIFT;
    assign acc_final_s = acc_q + prod_ext_s + bias_ext_s;

    preact_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc_i (acc_final_s),
        .x_o   (sat_x_s),
        .sat_o (sat_flag_s)
    );

    // Next-state and datapath update for ACC/FLUSH/OUT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        pend_d    = 1'b0;
        acc_d     = acc_q;
        bias_d    = bias_q;
        short_d   = short_q;
        m_x_d     = m_x_q;
        m_sat_d   = m_sat_q;
        m_short_d = m_short_q;
        case (state_q)
            ACC: begin
                acc_d = acc_q + prod_ext_s;
                if (beat_s) begin
                    prod_d = PROD_W'(bus.s_act * bus.s_wgt);
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        bias_d = bus.bias;
                    end else begin
                        bias_d = bias_q;
                    end
                    if (end_s) begin
                        state_d = FLUSH;
                        short_d = bus.s_last && (cnt_q < CNT_LAST);
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            FLUSH: begin
                acc_d     = acc_final_s;
                m_x_d     = sat_x_s;
                m_sat_d   = sat_flag_s;
                m_short_d = short_q;
                state_d   = OUT;
            end
            OUT: begin
                if (bus.m_ready) begin
                    state_d = ACC;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = ACC;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset discards any partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            cnt_q     <= {CNT_W{1'b0}};
            prod_q    <= {PROD_W{1'b0}};
            pend_q    <= 1'b0;
            acc_q     <= {ACC_W{1'b0}};
            bias_q    <= {X_W{1'b0}};
            short_q   <= 1'b0;
            m_x_q     <= {X_W{1'b0}};
            m_sat_q   <= 1'b0;
            m_short_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            pend_q    <= pend_d;
            acc_q     <= acc_d;
            bias_q    <= bias_d;
            short_q   <= short_d;
            m_x_q     <= m_x_d;
            m_sat_q   <= m_sat_d;
            m_short_q <= m_short_d;
        end
    end

    assign bus.s_ready = (state_q == ACC);
    assign bus.m_valid = (state_q == OUT);
    assign bus.m_x     = m_x_q;
    assign bus.m_sat   = m_sat_q;
    assign bus.m_short = m_short_q;

endmodule

// File: tb/tb_neuron_preact_mac.sv
// Directed-vector bench for neuron_preact_mac with N_IN=4, SHIFT=12.
module tb_neuron_preact_mac;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    neuron_preact_mac_if bus ();

    neuron_preact_mac #(
        .N_IN  (4),
        .SHIFT (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat after an optional bubble gap; returns 1ns after the accepting edge.
    task automatic beat(input logic signed [13:0] a, input logic signed [11:0] w,
                        input logic l, input logic signed [11:0] b, input int gap);
        int n;
        bus.s_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        bus.s_act   = a;
        bus.s_wgt   = w;
        bus.s_last  = l;
        bus.bias    = b;
        bus.s_valid = 1'b1;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_ready_wait", bus.s_ready, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Check FLUSH/OUT timing and result, then complete the handshake.
    task automatic finish_vec(input string tag, input int ex, input int es, input int esh);
        @(negedge clk);
        chk({tag, "_mv_t1"}, bus.m_valid, 0);
        @(negedge clk);
        chk({tag, "_mv_t2"}, bus.m_valid, 1);
        chk({tag, "_x"}, bus.m_x, ex);
        chk({tag, "_sat"}, bus.m_sat, es);
        chk({tag, "_short"}, bus.m_short, esh);
        chk({tag, "_srdy_out"}, bus.s_ready, 0);
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_mv_done"}, bus.m_valid, 0);
        chk({tag, "_srdy_done"}, bus.s_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_act   = '0;
        bus.s_wgt   = '0;
        bus.s_last  = 1'b0;
        bus.bias    = '0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_x", bus.m_x, 0);
        chk("rst_m_sat", bus.m_sat, 0);
        chk("rst_m_short", bus.m_short, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4 x (1.0 * 1.0) = 4.0 -> 1024
        for (int i = 0; i < 4; i++) beat(14'sd4096, 12'sd256, (i == 3), 12'sd0, 0);
        finish_vec("unity", 1024, 0, 0);

        // positive saturation
        for (int i = 0; i < 4; i++) beat(14'sd4096, 12'sd2047, (i == 3), 12'sd0, 0);
        finish_vec("satpos", 2047, 1, 0);

        // negative saturation clamps to -2047, not -2048
        for (int i = 0; i < 4; i++) beat(14'sd4096, -12'sd2048, (i == 3), 12'sd0, 0);
        finish_vec("satneg", -2047, 1, 0);

        // single beat, -1 LSB of Q.20 floors to -1
        beat(14'sd1, -12'sd1, 1'b1, 12'sd0, 0);
        finish_vec("floor", -1, 0, 1);

        // bias only, sampled on first beat; ends on count without s_last
        beat(14'sd4096, 12'sd0, 1'b0, 12'sd100, 0);
        for (int i = 0; i < 3; i++) beat(14'sd4096, 12'sd0, 1'b0, 12'sd0, 0);
        finish_vec("bias", 100, 0, 0);

        // 3-beat short vector -> -768, hold m_ready low for 10 cycles
        for (int i = 0; i < 3; i++) beat(-14'sd4096, 12'sd256, (i == 2), 12'sd0, 0);
        @(negedge clk);
        chk("hold_mv_t1", bus.m_valid, 0);
        @(negedge clk);
        chk("hold_mv_t2", bus.m_valid, 1);
        chk("hold_short", bus.m_short, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_x", bus.m_x, -768);
            chk("hold_srdy", bus.s_ready, 0);
            chk("hold_mv", bus.m_valid, 1);
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("release_srdy", bus.s_ready, 1);
        @(posedge clk); #1;

        // mixed vector: 100000-100000-90000+100000 + 5<<12 = 30480 -> 7
        beat(14'sd1000, 12'sd100, 1'b0, 12'sd5, 0);
        beat(-14'sd2000, 12'sd50, 1'b0, 12'sd0, 0);
        beat(14'sd3000, -12'sd30, 1'b0, 12'sd0, 0);
        beat(14'sd500, 12'sd200, 1'b1, 12'sd0, 0);
        finish_vec("nogap", 7, 0, 0);

        beat(14'sd1000, 12'sd100, 1'b0, 12'sd5, $urandom_range(1, 3));
        beat(-14'sd2000, 12'sd50, 1'b0, 12'sd0, $urandom_range(1, 3));
        beat(14'sd3000, -12'sd30, 1'b0, 12'sd0, $urandom_range(1, 3));
        beat(14'sd500, 12'sd200, 1'b1, 12'sd0, $urandom_range(1, 3));
        finish_vec("gap", 7, 0, 0);

        // reset asserted while beat 2 of 4 is presented
        beat(14'sd4096, 12'sd2047, 1'b0, 12'sd50, 0);
        bus.s_act   = 14'sd4096;
        bus.s_wgt   = 12'sd2047;
        bus.s_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_m_x", bus.m_x, 0);
        chk("abort_m_sat", bus.m_sat, 0);
        chk("abort_m_short", bus.m_short, 0);
        chk("abort_m_valid", bus.m_valid, 0);
        chk("abort_s_ready", bus.s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_s_ready2", bus.s_ready, 1);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) beat(14'sd4096, 12'sd256, (i == 3), 12'sd0, 0);
        finish_vec("fresh", 1024, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
